// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled serial receiver for 8N1-style frames.
// A 2-flop synchroniser feeds a start/data/stop FSM. Each data and stop bit is
// decided by a 3-sample majority vote. A stop bit sampled low raises a framing
// error, and also raises break when every data bit was zero. After a framing
// error the FSM waits for the line to return high before it looks for a new
// start bit, so a line held low cannot retrigger frames.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err,
  output logic            o_break,
  output logic            o_busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT + 1);

  localparam logic [SW-1:0] S_MID = SW'(7);
  localparam logic [SW-1:0] S_S0  = SW'(13);
  localparam logic [SW-1:0] S_S1  = SW'(14);
  localparam logic [SW-1:0] S_S2  = SW'(15);
  localparam logic [SW-1:0] S_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] sreg;
  logic [1:0]      smp;
  logic            stop_bit;
  logic            maj3;
  logic            stop_ok;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Majority of the samples taken at s_cnt 13 and 14 and the live sample at 15.
  // With more than 16 stop ticks, the vote is held in stop_bit until the
  // stop state ends.
  always_comb begin
    maj3    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    stop_ok = (s_cnt == S_S2) ? maj3 : stop_bit;
  end

  // Receive FSM. Counters move only on tick cycles. The idle and wait-idle
  // exits do not need a tick. All outputs are registered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      sreg           <= '0;
      smp            <= '0;
      stop_bit       <= 1'b0;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_break        <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_break        <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            s_cnt  <= '0;
            o_busy <= 1'b1;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (s_cnt == S_MID) begin
              if (rx_s) begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end else begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s_cnt == S_S0) smp[0] <= rx_s;
            if (s_cnt == S_S1) smp[1] <= rx_s;
            if (s_cnt == S_S2) begin
              // LSB arrives first, so each new bit enters at the MSB.
              sreg  <= DBIT'({maj3, sreg} >> 1);
              s_cnt <= '0;
              n_cnt <= n_cnt + 1'b1;
              if (n_cnt == N_LAST) state <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (s_cnt == S_S0) smp[0]   <= rx_s;
            if (s_cnt == S_S1) smp[1]   <= rx_s;
            if (s_cnt == S_S2) stop_bit <= maj3;
            if (s_cnt == S_END) begin
              s_cnt  <= '0;
              o_dout <= sreg;
              if (stop_ok) begin
                o_rx_done_tick <= 1'b1;
                state          <= IDLE;
                o_busy         <= 1'b0;
              end else begin
                o_frame_err <= 1'b1;
                o_break     <= (sreg == '0);
                state       <= WAIT_IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled: directed and random 8N1 frames checked
// against a frame-level model (stop high -> word, stop low -> error/break).
module tb_uart_rx_oversampled;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_s_tick = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_dout;
  logic       o_rx_done_tick;
  logic       o_frame_err;
  logic       o_break;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_err = 0, n_brk = 0, n_ovl = 0;
  int tcnt  = 0;
  logic [7:0] done_dout = '0;
  logic [7:0] err_dout  = '0;

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_s_tick       (i_s_tick),
    .i_rx           (i_rx),
    .o_dout         (o_dout),
    .o_rx_done_tick (o_rx_done_tick),
    .o_frame_err    (o_frame_err),
    .o_break        (o_break),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Oversample tick: one clock in every four.
  initial forever begin
    @(negedge i_clk);
    tcnt++;
    i_s_tick = (tcnt % 4 == 0);
  end

  // Pulse monitor, sampled away from the active edge.
  always @(negedge i_clk) begin
    if (o_rx_done_tick) begin n_done++; done_dout = o_dout; end
    if (o_frame_err)    begin n_err++;  err_dout  = o_dout; end
    if (o_break)        n_brk++;
    if (o_rx_done_tick && (o_frame_err || o_break)) n_ovl++;
    if (o_break && !o_frame_err) n_ovl++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge i_clk);
    while (!i_s_tick) @(posedge i_clk);
    #1;
  endtask

  task automatic hold(input bit v, input int n);
    i_rx = v;
    repeat (n) wait_tick();
  endtask

  // One frame on the line: start, 8 data bits LSB first, one stop bit, then
  // a short idle gap. Optional single-tick inversion inside data bit gbit.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int gbit, input int gtick);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      for (int j = 1; j <= 16; j++) begin
        i_rx = d[i] ^ ((i == gbit) && (j == gtick));
        wait_tick();
      end
      if (i == 0) chk("busy_mid", int'(o_busy), 1);
    end
    hold(stop, 16);
    hold(1'b1, 4);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit stop,
                           input int gbit, input int gtick);
    int d0, e0, b0;
    d0 = n_done; e0 = n_err; b0 = n_brk;
    send_frame(d, stop, gbit, gtick);
    // Model: a single-tick glitch never moves a 3-sample majority, so the
    // outcome depends only on the word and the stop level.
    chk({tag, "_done"}, n_done - d0, stop ? 1 : 0);
    chk({tag, "_err"},  n_err - e0,  stop ? 0 : 1);
    chk({tag, "_brk"},  n_brk - b0,  (!stop && d == 8'h00) ? 1 : 0);
    chk({tag, "_dout"}, int'(o_dout), int'(d));
    chk({tag, "_idle"}, int'(o_busy), 0);
  endtask

  initial begin
    int d0, e0, b0;
    logic [7:0] rd;
    bit rs;

    // Reset state
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_dout", int'(o_dout), 0);
    chk("rst_done", int'(o_rx_done_tick), 0);
    chk("rst_err",  int'(o_frame_err), 0);
    chk("rst_brk",  int'(o_break), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_reset = 1'b1;
    hold(1'b1, 8);

    // 1: clean frame
    run_frame("t1", 8'hA5, 1'b1, -1, 0);

    // 2: glitch start then valid frame
    d0 = n_done; e0 = n_err;
    hold(1'b0, 5);
    hold(1'b1, 12);
    chk("t2_false_done", n_done - d0, 0);
    chk("t2_false_err",  n_err - e0, 0);
    chk("t2_false_busy", int'(o_busy), 0);
    run_frame("t2", 8'h3C, 1'b1, -1, 0);

    // 3: stop bit low
    run_frame("t3", 8'h3C, 1'b0, -1, 0);

    // 4: break: line low for 20 bit-times
    d0 = n_done; e0 = n_err; b0 = n_brk;
    hold(1'b0, 320);
    chk("t4_err",  n_err - e0, 1);
    chk("t4_brk",  n_brk - b0, 1);
    chk("t4_done", n_done - d0, 0);
    chk("t4_dout", int'(err_dout), 0);
    chk("t4_busy_low", int'(o_busy), 1);
    hold(1'b1, 4);
    chk("t4_busy_high", int'(o_busy), 0);
    run_frame("t4b", 8'h81, 1'b1, -1, 0);

    // 5: single-tick glitch at s_cnt 14 of bit 3
    run_frame("t5", 8'h55, 1'b1, 3, 7);

    // 6: reset during bit 4 of 0xFF
    d0 = n_done; e0 = n_err; b0 = n_brk;
    hold(1'b0, 16);
    hold(1'b1, 4 * 16 + 8);
    i_reset = 1'b0;
    #1;
    chk("t6_dout", int'(o_dout), 0);
    chk("t6_busy", int'(o_busy), 0);
    repeat (4) @(posedge i_clk);
    #1;
    chk("t6_pulses", (n_done - d0) + (n_err - e0) + (n_brk - b0), 0);
    i_reset = 1'b1;
    hold(1'b1, 4);
    run_frame("t6b", 8'h12, 1'b1, -1, 0);

    // Random frames, glitches anywhere in the data bits
    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      if (k == 0) begin rd = 8'h00; rs = 1'b0; end
      run_frame("rnd", rd, rs, int'($urandom_range(0, 8)), int'($urandom_range(1, 16)));
    end

    chk("pulse_overlap", n_ovl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
